// File: rtl/scratchpad_pkg.sv
// scratchpad_pkg
//   Shared types and helpers for the dual-port scratchpad.
//   - fill_state_t : zero-fill engine states (IDLE, CLEAR, DONE)
//   - lane_count() : number of byte lanes in a data word
package scratchpad_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } fill_state_t;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/scratchpad_if.sv
// scratchpad_if
//   One Avalon-MM port of the scratchpad (word addressed, byte enables,
//   pipelined reads with readdatavalid).
//   master modport: drives address/byteenable/read/write/writedata,
//                   receives waitrequest/readdata/readdatavalid.
//   slave modport : the mirror image, used by scratchpad_dp.
interface scratchpad_if
  import scratchpad_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
);

  logic [ADDR_W-1:0]               address;
  logic [lane_count(DATA_W)-1:0]   byteenable;
  logic                            read;
  logic                            write;
  logic [DATA_W-1:0]               writedata;
  logic                            waitrequest;
  logic [DATA_W-1:0]               readdata;
  logic                            readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/scratchpad_dp_ram.sv
// scratchpad_dp_ram
//   Inferred true-dual-port RAM, byte-lane write enables, read-first.
//   Ports (x = a, b):
//     clk, reset, clken : clock, sync reset (output registers only), enable
//     x_addr   : word address
//     x_we     : per-lane write enable (already qualified by the caller)
//     x_wdata  : write data
//     x_rd_en  : load the read register from x_addr this cycle
//     x_rdata  : read data; one register deep, or two when READ_LATENCY==2
//   Memory contents are never reset. A read of an address written in the
//   same cycle (either port) returns the old contents.
module scratchpad_dp_ram
  import scratchpad_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 14,
  parameter int READ_LATENCY = 1,
  localparam int LANES       = lane_count(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clken,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [LANES-1:0]  a_we,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              a_rd_en,
  output logic [DATA_W-1:0] a_rdata,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [LANES-1:0]  b_we,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_rd_en,
  output logic [DATA_W-1:0] b_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;

  // One narrow memory per byte lane keeps the byte-enable write a plain
  // full-width write per array, which inference tools map cleanly.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] a_q_reg;
    logic [7:0] b_q_reg;

    // Both ports in one process; the caller never lets them write the
    // same address in the same cycle, so the order here is irrelevant.
    always_ff @(posedge clk) begin
      if (clken) begin
        if (a_we[gi]) mem[a_addr] <= a_wdata[gi*8 +: 8];
        if (b_we[gi]) mem[b_addr] <= b_wdata[gi*8 +: 8];
      end
    end

    // Read registers load only on an accepted read so they hold the last
    // returned word between valids.
    always_ff @(posedge clk) begin
      if (reset) begin
        a_q_reg <= '0;
        b_q_reg <= '0;
      end else if (clken) begin
        if (a_rd_en) a_q_reg <= mem[a_addr];
        if (b_rd_en) b_q_reg <= mem[b_addr];
      end
    end

    assign a_q[gi*8 +: 8] = a_q_reg;
    assign b_q[gi*8 +: 8] = b_q_reg;
  end

  if (READ_LATENCY == 2) begin : g_out_reg
    logic              a_pend_reg;
    logic              b_pend_reg;
    logic [DATA_W-1:0] a_out_reg;
    logic [DATA_W-1:0] b_out_reg;

    // The output register advances only when the read register holds a
    // freshly read word, again so readdata holds between valids.
    always_ff @(posedge clk) begin
      if (reset) begin
        a_pend_reg <= 1'b0;
        b_pend_reg <= 1'b0;
        a_out_reg  <= '0;
        b_out_reg  <= '0;
      end else if (clken) begin
        a_pend_reg <= a_rd_en;
        b_pend_reg <= b_rd_en;
        if (a_pend_reg) a_out_reg <= a_q;
        if (b_pend_reg) b_out_reg <= b_q;
      end
    end

    assign a_rdata = a_out_reg;
    assign b_rdata = b_out_reg;
  end else begin : g_no_out_reg
    assign a_rdata = a_q;
    assign b_rdata = b_q;
  end

endmodule

// File: rtl/scratchpad_dp.sv
// scratchpad_dp
//   Dual-port scratchpad shared by the CPU (port a) and an accelerator
//   (port b), with a hardware zero-fill engine.
//   Ports:
//     clk, reset     : clock, synchronous active-high reset
//     clken          : global enable; 0 freezes every register and the RAM
//     a, b           : Avalon-MM slave ports (scratchpad_if.slave)
//     clear          : start a zero-fill (ignored while one is running)
//     busy           : zero-fill in progress
//     clear_done     : one-cycle pulse after the last word is cleared
//   READ_LATENCY must be 1 or 2. With CLEAR_ON_RESET=1 a fill starts on
//   its own as soon as reset is released.
module scratchpad_dp
  import scratchpad_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 14,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clken,
  scratchpad_if.slave a,
  scratchpad_if.slave b,
  input  logic clear,
  output logic busy,
  output logic clear_done
);

  localparam int LANES = lane_count(DATA_W);

  fill_state_t       state_reg;
  logic [ADDR_W-1:0] clr_cnt_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              init_pend_reg;

  logic              filling;
  logic              collide;
  logic              a_wr_acc;
  logic              a_rd_acc;
  logic              b_wr_acc;
  logic              b_rd_acc;

  logic [ADDR_W-1:0] ram_a_addr;
  logic [LANES-1:0]  ram_a_we;
  logic [DATA_W-1:0] ram_a_wdata;
  logic [LANES-1:0]  ram_b_we;

  logic [READ_LATENCY-1:0] a_vld_reg;
  logic [READ_LATENCY-1:0] b_vld_reg;

  // ---------------------------------------------------------------------
  // Stalls and acceptance
  // ---------------------------------------------------------------------
  assign filling = (state_reg != IDLE);

  // Only a write/write clash on one address stalls, and only port b;
  // reads never hold off the other port.
  assign collide = a.write & b.write & (a.address == b.address);

  assign a.waitrequest = filling;
  assign b.waitrequest = filling | collide;

  // read+write together is treated as a write.
  assign a_wr_acc = a.write & ~a.waitrequest & clken;
  assign a_rd_acc = a.read & ~a.write & ~a.waitrequest & clken;
  assign b_wr_acc = b.write & ~b.waitrequest & clken;
  assign b_rd_acc = b.read & ~b.write & ~b.waitrequest & clken;

  // The fill engine borrows RAM port a; user traffic is stalled meanwhile.
  always_comb begin
    ram_a_addr  = a.address;
    ram_a_we    = '0;
    ram_a_wdata = a.writedata;
    if (state_reg == CLEAR) begin
      ram_a_addr  = clr_cnt_reg;
      ram_a_we    = '1;
      ram_a_wdata = '0;
    end else if (a_wr_acc) begin
      ram_a_we    = a.byteenable;
    end
  end

  assign ram_b_we = b_wr_acc ? b.byteenable : '0;

  // ---------------------------------------------------------------------
  // Zero-fill FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      clr_cnt_reg   <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      init_pend_reg <= 1'(CLEAR_ON_RESET);
    end else if (clken) begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (clear | init_pend_reg) begin
            state_reg     <= CLEAR;
            clr_cnt_reg   <= '0;
            busy_reg      <= 1'b1;
            init_pend_reg <= 1'b0;
          end
        end
        CLEAR: begin
          clr_cnt_reg <= clr_cnt_reg + ADDR_W'(1);
          // All-ones counter is the last word, DEPTH-1.
          if (&clr_cnt_reg) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_reg;
  assign clear_done = done_reg;

  // ---------------------------------------------------------------------
  // Read-valid pipelines: one flag per latency stage, frozen by clken.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      a_vld_reg <= '0;
      b_vld_reg <= '0;
    end else if (clken) begin
      a_vld_reg[0] <= a_rd_acc;
      b_vld_reg[0] <= b_rd_acc;
      for (int i = 1; i < READ_LATENCY; i++) begin
        a_vld_reg[i] <= a_vld_reg[i-1];
        b_vld_reg[i] <= b_vld_reg[i-1];
      end
    end
  end

  // A valid held during a clken=0 stretch is masked and reappears when
  // clken returns, so it is delivered exactly once.
  assign a.readdatavalid = a_vld_reg[READ_LATENCY-1] & clken;
  assign b.readdatavalid = b_vld_reg[READ_LATENCY-1] & clken;

  scratchpad_dp_ram #(
    .DATA_W       (DATA_W),
    .ADDR_W       (ADDR_W),
    .READ_LATENCY (READ_LATENCY)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .clken   (clken),
    .a_addr  (ram_a_addr),
    .a_we    (ram_a_we),
    .a_wdata (ram_a_wdata),
    .a_rd_en (a_rd_acc),
    .a_rdata (a.readdata),
    .b_addr  (b.address),
    .b_we    (ram_b_we),
    .b_wdata (b.writedata),
    .b_rd_en (b_rd_acc),
    .b_rdata (b.readdata)
  );

endmodule

// File: tb/tb_scratchpad_dp.sv
// tb_scratchpad_dp
//   Directed bench for scratchpad_dp. Two instances (READ_LATENCY 1 and 2,
//   DEPTH 16) receive identical stimulus; each is checked against its own
//   latency. Inputs change on the falling edge, outputs are sampled there.
module tb_scratchpad_dp;

  logic clk = 1'b0;
  logic reset;
  logic clken;
  logic clear;
  logic busy1, done1, busy2, done2;

  int checks = 0;
  int errors = 0;

  scratchpad_if #(.DATA_W(32), .ADDR_W(4)) ia1 ();
  scratchpad_if #(.DATA_W(32), .ADDR_W(4)) ib1 ();
  scratchpad_if #(.DATA_W(32), .ADDR_W(4)) ia2 ();
  scratchpad_if #(.DATA_W(32), .ADDR_W(4)) ib2 ();

  scratchpad_dp #(.DATA_W(32), .ADDR_W(4), .READ_LATENCY(1), .CLEAR_ON_RESET(0)) dut1 (
    .clk(clk), .reset(reset), .clken(clken), .a(ia1), .b(ib1),
    .clear(clear), .busy(busy1), .clear_done(done1)
  );

  scratchpad_dp #(.DATA_W(32), .ADDR_W(4), .READ_LATENCY(2), .CLEAR_ON_RESET(0)) dut2 (
    .clk(clk), .reset(reset), .clken(clken), .a(ia2), .b(ib2),
    .clear(clear), .busy(busy2), .clear_done(done2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_a(input logic rd, input logic wr, input logic [3:0] addr,
                         input logic [3:0] be, input logic [31:0] d);
    ia1.read = rd; ia1.write = wr; ia1.address = addr; ia1.byteenable = be; ia1.writedata = d;
    ia2.read = rd; ia2.write = wr; ia2.address = addr; ia2.byteenable = be; ia2.writedata = d;
  endtask

  task automatic drive_b(input logic rd, input logic wr, input logic [3:0] addr,
                         input logic [3:0] be, input logic [31:0] d);
    ib1.read = rd; ib1.write = wr; ib1.address = addr; ib1.byteenable = be; ib1.writedata = d;
    ib2.read = rd; ib2.write = wr; ib2.address = addr; ib2.byteenable = be; ib2.writedata = d;
  endtask

  task automatic idle_all();
    drive_a(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    drive_b(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  // Presents one port-a write; the next task call (or idle) replaces it.
  task automatic write_a(input logic [3:0] addr, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    drive_a(1'b0, 1'b1, addr, be, d);
    drive_b(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  // Single read on port a or b, checked on both latency builds.
  task automatic read_chk(input bit on_b, input logic [3:0] addr, input logic [31:0] exp,
                          input string tag);
    @(negedge clk);
    if (on_b) begin
      drive_a(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
      drive_b(1'b1, 1'b0, addr, 4'h0, 32'h0);
    end else begin
      drive_a(1'b1, 1'b0, addr, 4'h0, 32'h0);
      drive_b(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    end
    @(negedge clk);
    idle_all();
    #1;
    chk({tag, " lat1 valid"}, on_b ? ib1.readdatavalid : ia1.readdatavalid, 32'd1);
    chk({tag, " lat1 data"},  on_b ? ib1.readdata : ia1.readdata, exp);
    chk({tag, " lat2 early"}, on_b ? ib2.readdatavalid : ia2.readdatavalid, 32'd0);
    @(negedge clk);
    #1;
    chk({tag, " lat2 valid"}, on_b ? ib2.readdatavalid : ia2.readdatavalid, 32'd1);
    chk({tag, " lat2 data"},  on_b ? ib2.readdata : ia2.readdata, exp);
    chk({tag, " lat1 single"}, on_b ? ib1.readdatavalid : ia1.readdatavalid, 32'd0);
  endtask

  // Reads addresses 0..n-1 on port a on consecutive cycles.
  task automatic burst_read(input int n, input logic [31:0] exp [16], input string tag);
    for (int k = 0; k <= n + 1; k++) begin
      @(negedge clk);
      if (k < n) drive_a(1'b1, 1'b0, 4'(k), 4'h0, 32'h0);
      else       drive_a(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
      #1;
      if (k < n) chk($sformatf("%s wait k%0d", tag, k), ia1.waitrequest, 32'd0);
      chk($sformatf("%s lat1 valid k%0d", tag, k), ia1.readdatavalid, 32'(k >= 1 && k <= n));
      if (k >= 1 && k <= n) chk($sformatf("%s lat1 data k%0d", tag, k), ia1.readdata, exp[k-1]);
      chk($sformatf("%s lat2 valid k%0d", tag, k), ia2.readdatavalid, 32'(k >= 2));
      if (k >= 2) chk($sformatf("%s lat2 data k%0d", tag, k), ia2.readdata, exp[k-2]);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] vec [16];
    int          active;

    reset = 1'b1;
    clken = 1'b1;
    clear = 1'b0;
    idle_all();
    repeat (3) @(negedge clk);
    #1;
    chk("rst a_wait",  ia1.waitrequest, 32'd0);
    chk("rst b_wait",  ib1.waitrequest, 32'd0);
    chk("rst a_valid", ia1.readdatavalid, 32'd0);
    chk("rst a_data",  ia1.readdata, 32'd0);
    chk("rst b_data2", ib2.readdata, 32'd0);
    chk("rst busy",    busy1, 32'd0);
    chk("rst done",    done1, 32'd0);
    reset = 1'b0;

    // 1: byte-lane merge. 0x10 does not fit a 4-bit address, so 0xA is used.
    write_a(4'hA, 4'hF, 32'hDEADBEEF);
    write_a(4'hA, 4'h1, 32'h000000AA);
    read_chk(1'b0, 4'hA, 32'hDEADBEAA, "t1 merge");
    $display("t1 byte-enable merge done, checks=%0d errors=%0d", checks, errors);

    // 2: back-to-back reads of 0..7
    for (int i = 0; i < 8; i++) write_a(4'(i), 4'hF, 32'hC0DE0000 + 32'(i));
    for (int i = 0; i < 16; i++) vec[i] = 32'hC0DE0000 + 32'(i);
    burst_read(8, vec, "t2");
    $display("t2 pipelined burst done, checks=%0d errors=%0d", checks, errors);

    // 3: write/write collision on address 5
    @(negedge clk);
    drive_a(1'b0, 1'b1, 4'h5, 4'hF, 32'h11111111);
    drive_b(1'b0, 1'b1, 4'h5, 4'hF, 32'h22222222);
    #1;
    chk("t3 b_wait clash", ib1.waitrequest, 32'd1);
    chk("t3 a_wait clash", ia1.waitrequest, 32'd0);
    @(negedge clk);
    drive_a(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    #1;
    chk("t3 b_wait retry", ib1.waitrequest, 32'd0);
    read_chk(1'b0, 4'h5, 32'h22222222, "t3 b wins");
    $display("t3 collision done, checks=%0d errors=%0d", checks, errors);

    // 4: cross-port read during write returns old data
    write_a(4'h7, 4'hF, 32'h00000033);
    @(negedge clk);
    drive_a(1'b0, 1'b1, 4'h7, 4'hF, 32'h00000055);
    drive_b(1'b1, 1'b0, 4'h7, 4'h0, 32'h0);
    @(negedge clk);
    idle_all();
    #1;
    chk("t4 old lat1 valid", ib1.readdatavalid, 32'd1);
    chk("t4 old lat1 data",  ib1.readdata, 32'h00000033);
    @(negedge clk);
    #1;
    chk("t4 old lat2 valid", ib2.readdatavalid, 32'd1);
    chk("t4 old lat2 data",  ib2.readdata, 32'h00000033);
    read_chk(1'b1, 4'h7, 32'h00000055, "t4 new");
    $display("t4 read-during-write done, checks=%0d errors=%0d", checks, errors);

    // 5: zero-fill of all 16 words; a second clear mid-fill is ignored
    write_a(4'hF, 4'hF, 32'hFFFFFFFF);
    @(negedge clk);
    idle_all();
    clear = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      clear = (i == 4);
      #1;
      chk($sformatf("t5 busy c%0d", i), busy1, 32'd1);
      chk($sformatf("t5 done c%0d", i), done1, 32'd0);
      chk($sformatf("t5 a_wait c%0d", i), ia1.waitrequest, 32'd1);
      chk($sformatf("t5 b_wait c%0d", i), ib1.waitrequest, 32'd1);
    end
    @(negedge clk);
    #1;
    chk("t5 done pulse", done1, 32'd1);
    chk("t5 done busy",  busy1, 32'd0);
    chk("t5 done wait",  ia1.waitrequest, 32'd1);
    chk("t5 done pulse lat2", done2, 32'd1);
    @(negedge clk);
    #1;
    chk("t5 after done", done1, 32'd0);
    chk("t5 after wait", ia1.waitrequest, 32'd0);
    for (int i = 0; i < 16; i++) vec[i] = 32'h0;
    burst_read(16, vec, "t5 zero");
    $display("t5 zero-fill done, checks=%0d errors=%0d", checks, errors);

    // 6a: reset during cycle 5 of a fill
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("t6 busy before rst", busy1, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6 busy after rst", busy1, 32'd0);
    chk("t6 wait after rst", ia1.waitrequest, 32'd0);
    active = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (busy1 || done1 || busy2 || done2) active++;
    end
    chk("t6 stays idle", 32'(active), 32'd0);

    // 6b: clken low for 3 cycles right after a read is accepted
    write_a(4'h5, 4'hF, 32'h12345678);
    @(negedge clk);
    drive_a(1'b1, 1'b0, 4'h5, 4'h0, 32'h0);
    @(negedge clk);
    idle_all();
    clken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk($sformatf("t6 frozen lat1 c%0d", i), ia1.readdatavalid, 32'd0);
      chk($sformatf("t6 frozen lat2 c%0d", i), ia2.readdatavalid, 32'd0);
    end
    @(negedge clk);
    clken = 1'b1;
    #1;
    chk("t6 late lat1 valid", ia1.readdatavalid, 32'd1);
    chk("t6 late lat1 data",  ia1.readdata, 32'h12345678);
    chk("t6 late lat2 early", ia2.readdatavalid, 32'd0);
    @(negedge clk);
    #1;
    chk("t6 late lat1 once",  ia1.readdatavalid, 32'd0);
    chk("t6 late lat2 valid", ia2.readdatavalid, 32'd1);
    chk("t6 late lat2 data",  ia2.readdata, 32'h12345678);
    @(negedge clk);
    #1;
    chk("t6 lat2 once",  ia2.readdatavalid, 32'd0);
    chk("t6 lat1 hold",  ia1.readdata, 32'h12345678);
    chk("t6 lat2 hold",  ia2.readdata, 32'h12345678);
    $display("t6 reset/clken done, checks=%0d errors=%0d", checks, errors);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
